// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer with HI/LO registers for the E stage.
// Define MD_FLUSH_EN to let md_flush_i cancel an in-flight operation.
module muldiv_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start_i,
  input  logic [1:0]  md_op_i,
  input  logic [31:0] md_a_i,
  input  logic [31:0] md_b_i,
  input  logic [1:0]  md_wsel_i,
  input  logic [31:0] md_wd_i,
  input  logic        md_use_D_i,
  input  logic        md_flush_i,
  output logic        md_busy_o,
  output logic        md_stall_o,
  output logic [31:0] md_hi_o,
  output logic [31:0] md_lo_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               flush;

`ifdef MD_FLUSH_EN
  assign flush = md_flush_i;
`else
  assign flush = md_flush_i & 1'b0;
`endif

  logic        sgn_m, a_neg, b_neg, b_zero;
  logic [31:0] a_abs, b_abs, dvs, uq, ur;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Signed divide runs on magnitudes, then signs are restored
  always_comb begin
    sgn_m  = ~op_q[0];
    prod   = {{32{sgn_m & a_q[31]}}, a_q} *
             {{32{sgn_m & b_q[31]}}, b_q};
    a_neg  = (op_q == 2'b10) & a_q[31];
    b_neg  = (op_q == 2'b10) & b_q[31];
    a_abs  = a_neg ? -a_q : a_q;
    b_abs  = b_neg ? -b_q : b_q;
    b_zero = (b_q == 32'd0);
    dvs    = b_zero ? 32'd1 : b_abs;
    uq     = a_abs / dvs;
    ur     = a_abs % dvs;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_q[1]) begin
      if (b_zero) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = a_neg ? -ur : ur;
        res_lo = (a_neg ^ b_neg) ? -uq : uq;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md_start_i & ~flush) begin
          op_d    = md_op_i;
          a_d     = md_a_i;
          b_d     = md_b_i;
          cnt_d   = md_op_i[1] ? CNT_W'(DIV_CYCLES)
                               : CNT_W'(MULT_CYCLES);
          state_d = BUSY;
        end else if (md_wsel_i == 2'b01) begin
          hi_d = md_wd_i;
        end else if (md_wsel_i == 2'b10) begin
          lo_d = md_wd_i;
        end
      end
      BUSY: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_busy_o  = (state_q == BUSY);
  assign md_stall_o = md_use_D_i & (md_start_i | md_busy_o);
  assign md_hi_o    = hi_q;
  assign md_lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched against an arithmetic model.
// Flush scenarios are exercised when MD_FLUSH_EN is defined.
module tb_muldiv_sched;

`ifdef MD_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        md_start_i = 1'b0;
  logic [1:0]  md_op_i = '0;
  logic [31:0] md_a_i = '0;
  logic [31:0] md_b_i = '0;
  logic [1:0]  md_wsel_i = '0;
  logic [31:0] md_wd_i = '0;
  logic        md_use_D_i = 1'b0;
  logic        md_flush_i = 1'b0;
  logic        md_busy_o, md_stall_o;
  logic [31:0] md_hi_o, md_lo_o;

  int checks = 0;
  int errors = 0;

  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  muldiv_sched dut (
    .clk(clk), .reset(reset),
    .md_start_i(md_start_i), .md_op_i(md_op_i),
    .md_a_i(md_a_i), .md_b_i(md_b_i),
    .md_wsel_i(md_wsel_i), .md_wd_i(md_wd_i),
    .md_use_D_i(md_use_D_i), .md_flush_i(md_flush_i),
    .md_busy_o(md_busy_o), .md_stall_o(md_stall_o),
    .md_hi_o(md_hi_o), .md_lo_o(md_lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {HI,LO} from the instruction-set definition
  function automatic logic [63:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  task automatic model_edge();
    if (m_left > 0) begin
      if (FLUSH && md_flush_i) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) {m_hi, m_lo} = m_pend;
      end
    end else if (md_start_i && !(FLUSH && md_flush_i)) begin
      m_left = md_op_i[1] ? 10 : 5;
      m_pend = ref_res(md_op_i, md_a_i, md_b_i);
    end else if (md_wsel_i == 2'b01) begin
      m_hi = md_wd_i;
    end else if (md_wsel_i == 2'b10) begin
      m_lo = md_wd_i;
    end
  endtask

  task automatic step(input logic st, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] ws, input logic [31:0] wd,
                      input logic ud, input logic fl);
    md_start_i = st;
    md_op_i    = op;
    md_a_i     = a;
    md_b_i     = b;
    md_wsel_i  = ws;
    md_wd_i    = wd;
    md_use_D_i = ud;
    md_flush_i = fl;
    #1;
    chk("stall", 32'(md_stall_o), 32'(ud & (st | (m_left > 0))));
    @(posedge clk);
    #1;
    model_edge();
    chk("busy", 32'(md_busy_o), 32'(m_left > 0));
    chk("hi", md_hi_o, m_hi);
    chk("lo", md_lo_o, m_lo);
  endtask

  task automatic idle(input int n, input logic ud);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, ud, 0);
  endtask

  initial begin
    md_use_D_i = 1'b1;
    #1;
    chk("rst_busy", 32'(md_busy_o), 32'd0);
    chk("rst_stall", 32'(md_stall_o), 32'd0);
    chk("rst_hi", md_hi_o, 32'd0);
    chk("rst_lo", md_lo_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    step(1, 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 1, 0);
    idle(5, 1);
    chk("mult_hi", md_hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", md_lo_o, 32'hFFFF_FFEB);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    step(1, 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
    idle(5, 0);
    chk("multu_hi", md_hi_o, 32'd1);
    chk("multu_lo", md_lo_o, 32'hFFFF_FFFE);

    step(1, 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    idle(9, 0);
    chk("div_busy9", 32'(md_busy_o), 32'd1);
    idle(1, 0);
    chk("div_lo", md_lo_o, 32'hFFFF_FFFD);
    chk("div_hi", md_hi_o, 32'hFFFF_FFFF);

    step(1, 2'b11, 32'd7, 32'd0, 0, 0, 0, 0);
    idle(10, 0);
    chk("divu0_lo", md_lo_o, 32'hFFFF_FFFF);
    chk("divu0_hi", md_hi_o, 32'd7);

    step(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    idle(10, 0);
    chk("ovf_lo", md_lo_o, 32'h8000_0000);
    chk("ovf_hi", md_hi_o, 32'd0);

    step(0, 0, 0, 0, 2'b10, 32'h1234, 0, 0);
    chk("mtlo", md_lo_o, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    step(1, 2'b00, 32'd3, 32'd3, 2'b01, 32'hDEAD, 0, 0);
    idle(5, 0);

    if (FLUSH) begin
      step(0, 0, 0, 0, 2'b01, 32'd5, 0, 0);
      step(0, 0, 0, 0, 2'b10, 32'd5, 0, 0);
      step(1, 2'b00, 32'd100, 32'd100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("flush_busy", 32'(md_busy_o), 32'd0);
      idle(6, 0);
      chk("flush_hi", md_hi_o, 32'd5);
      chk("flush_lo", md_lo_o, 32'd5);
      step(1, 2'b01, 32'd9, 32'd9, 0, 0, 1, 1);
      chk("flush_start", 32'(md_busy_o), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [1:0]  ws;
      logic        fl;
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      fl = ($urandom_range(0, 15) == 0);
      ws = fl ? 2'b00 : 2'($urandom());
      step(logic'($urandom_range(0, 3) == 0), 2'($urandom()), a, b,
           ws, $urandom(), logic'($urandom()), fl);
    end
    idle(12, 0);

    step(1, 2'b10, 32'd1000, 32'd7, 0, 0, 0, 0);
    idle(2, 0);
    reset = 1'b1;
    #1;
    m_left = 0;
    m_hi   = '0;
    m_lo   = '0;
    chk("rstmid_busy", 32'(md_busy_o), 32'd0);
    chk("rstmid_hi", md_hi_o, 32'd0);
    chk("rstmid_lo", md_lo_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
